// File: rtl/vmx_pkg.sv
// vmx_pkg: shared constants, the controller state encoding and the
// result-latency helper for the vector-MAC systolic array controller.
package vmx_pkg;

  // Load tags travel with the data along each row. Bit 7 set means
  // "load this data word as the weight of column tag[6:0]".
  localparam logic [7:0] TAG_IDLE = 8'h7F;
  localparam logic [7:0] TAG_LOAD = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } vmx_state_e;

  // Number of edges between an x acceptance and the registered result.
  function automatic int vmx_lat(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/vmx_skew_line.sv
// vmx_skew_line: WIDTH-bit register delay line, DEPTH stages (DEPTH >= 1).
// Every stage loads RST_VAL while rst_n is low (synchronous reset).
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   din    in   WIDTH  value entering stage 0
//   dout   out  WIDTH  value leaving the last stage
module vmx_skew_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vmx_array_ctrl.sv
// vmx_array_ctrl: sequencer for a ROWS x COLS systolic array of vector-MAC
// PEs. Loads column weights with load tags, skews input vectors per row,
// de-skews the bottom-row column sums into one aligned result word, owns
// the array simd_mode and holds off weight reloads until results drain.
//
//   clk            in   clock
//   rst_n          in   synchronous active-low reset (also clears the array)
//   cfg_simd       in   simd mode, sampled on the first LOAD beat
//   w_valid/ready  in/out  weight beat handshake; beat j carries column j
//   w_data         in   ROWS*DW  weight beat, row r in slice r
//   x_valid/ready  in/out  input vector handshake
//   x_data         in   ROWS*DW  input vector, row r in slice r
//   y_valid        out  result valid (no backpressure)
//   y_data         out  COLS*SW  result, column c in slice c
//   arr_data       out  ROWS*DW  to PE(r,0) data input
//   arr_load_ctrl  out  ROWS*8   to PE(r,0) load_ctrl input
//   arr_simd       out  ROWS     to PE(r,0) simd_mode input
//   arr_sum        in   COLS*SW  sum_out of PE(ROWS-1,c)
//   busy           out  state not READY, or results still in flight
//
// state | meaning
// IDLE  | no weights loaded, nothing accepted until a weight request
// LOAD  | accepting COLS weight beats, one column per beat
// READY | weights loaded, streaming x vectors
// DRAIN | reload requested, waiting for in-flight results to leave
module vmx_array_ctrl
  import vmx_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_simd,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [ROWS*DW-1:0]   w_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [ROWS*DW-1:0]   x_data,
  output logic                 y_valid,
  output logic [COLS*2*DW-1:0] y_data,
  output logic [ROWS*DW-1:0]   arr_data,
  output logic [ROWS*8-1:0]    arr_load_ctrl,
  output logic [ROWS-1:0]      arr_simd,
  input  logic [COLS*2*DW-1:0] arr_sum,
  output logic                 busy
);

  localparam int SW  = 2 * DW;
  localparam int LAT = vmx_lat(ROWS, COLS);
  localparam int IW  = $clog2(LAT + 1);
  localparam int BW  = 1 + 8 + DW;

  vmx_state_e    state_q, state_d;
  logic [6:0]    col_q;
  logic          simd_q;
  logic [IW-1:0] inflight_q;
  logic          y_valid_q;

  logic          w_acc, x_acc, y_set, first_beat, last_beat;
  logic          simd_in;
  logic [7:0]    tag_in;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    w_ready = 1'b0;
    x_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        if (last_beat) state_d = ST_READY;
      end
      ST_READY: begin
        // A pending weight request takes priority over new vectors.
        x_ready = !w_valid;
        if (w_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait until the last result has also left the output register.
        if (inflight_q == '0 && !y_valid_q) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_acc      = w_valid && w_ready;
  assign x_acc      = x_valid && x_ready;
  assign first_beat = w_acc && (col_q == '0);
  assign last_beat  = w_acc && (col_q == 7'(COLS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      simd_q     <= 1'b0;
      inflight_q <= '0;
      y_valid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_valid_q <= y_set;
      if (w_acc) col_q <= last_beat ? 7'd0 : col_q + 7'd1;
      if (first_beat) simd_q <= cfg_simd;
      // Decrement on the cycle the result is registered, so the count
      // never exceeds LAT in a continuous stream.
      unique case ({x_acc, y_set})
        2'b10:   inflight_q <= inflight_q + IW'(1);
        2'b01:   inflight_q <= inflight_q - IW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // ------------------------------------------------------- row skewing
  // The first beat already carries the newly sampled mode so the array
  // sees the new simd setting together with the first load tag.
  assign simd_in = first_beat ? cfg_simd : simd_q;
  assign tag_in  = w_acc ? (TAG_LOAD | {1'b0, col_q}) : TAG_IDLE;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] row_src;
    logic [BW-1:0] row_in, row_out;

    assign row_src = w_acc ? w_data[r*DW +: DW] :
                     x_acc ? x_data[r*DW +: DW] : '0;
    assign row_in  = {simd_in, tag_in, row_src};

    vmx_skew_line #(
      .WIDTH  (BW),
      .DEPTH  (r + 1),
      .RST_VAL({1'b0, TAG_IDLE, {DW{1'b0}}})
    ) u_row_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (row_in),
      .dout (row_out)
    );

    assign arr_data[r*DW +: DW]   = row_out[DW-1:0];
    assign arr_load_ctrl[r*8 +: 8] = row_out[DW +: 8];
    assign arr_simd[r]             = row_out[BW-1];
  end

  // ---------------------------------------------------- column de-skew
  // Column c finishes c cycles after column 0; COLS-1-c alignment stages
  // plus the output register line every column up on the same edge.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    vmx_skew_line #(
      .WIDTH  (SW),
      .DEPTH  (COLS - c),
      .RST_VAL('0)
    ) u_col_deskew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (arr_sum[c*SW +: SW]),
      .dout (y_data[c*SW +: SW])
    );
  end

  // Accept pulse delayed so y_set lines up with the cycle the aligned
  // result word is captured by the output registers.
  vmx_skew_line #(
    .WIDTH  (1),
    .DEPTH  (LAT),
    .RST_VAL(1'b0)
  ) u_valid_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (x_acc),
    .dout (y_set)
  );

  assign y_valid = y_valid_q;
  assign busy    = (state_q != ST_READY) || (inflight_q != '0);

endmodule
